// File: rtl/ipsl_pcie_dbi_apb_arb_pkg.sv
// Shared definitions for the DBI APB arbiter: FSM encoding and timeout defaults.
package ipsl_pcie_dbi_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam int unsigned TO_CYCLES_DEF = 1023;
    localparam int unsigned TO_W_DEF      = 10;

endpackage

// File: rtl/ipsl_pcie_dbi_apb_arb_if.sv
// Request/completion ports of both requesters plus the APB side of the DBI bridge.
interface ipsl_pcie_dbi_apb_arb_if;

    logic        req0_valid;
    logic        req0_we;
    logic [15:0] req0_addr;
    logic [31:0] req0_wdata;
    logic [3:0]  req0_strb;
    logic        req0_done;
    logic [31:0] req0_rdata;
    logic        req0_err;

    logic        req1_valid;
    logic        req1_we;
    logic [15:0] req1_addr;
    logic [31:0] req1_wdata;
    logic [3:0]  req1_strb;
    logic        req1_done;
    logic [31:0] req1_rdata;
    logic        req1_err;

    logic        p_sel;
    logic        p_ce;
    logic        p_we;
    logic [15:0] p_addr;
    logic [31:0] p_wdata;
    logic [3:0]  p_strb;
    logic        p_rdy;
    logic [31:0] p_rdata;

    // Arbiter side
    modport slave (
        input  req0_valid, req0_we, req0_addr, req0_wdata, req0_strb,
        input  req1_valid, req1_we, req1_addr, req1_wdata, req1_strb,
        input  p_rdy, p_rdata,
        output req0_done, req0_rdata, req0_err,
        output req1_done, req1_rdata, req1_err,
        output p_sel, p_ce, p_we, p_addr, p_wdata, p_strb
    );

    // Requester/bridge environment side
    modport master (
        output req0_valid, req0_we, req0_addr, req0_wdata, req0_strb,
        output req1_valid, req1_we, req1_addr, req1_wdata, req1_strb,
        output p_rdy, p_rdata,
        input  req0_done, req0_rdata, req0_err,
        input  req1_done, req1_rdata, req1_err,
        input  p_sel, p_ce, p_we, p_addr, p_wdata, p_strb
    );

endinterface

// File: rtl/ipsl_pcie_dbi_apb_arb_rr_arb2.sv
// Combinational two-way round-robin grant: on a tie the port not granted last wins.
module ipsl_pcie_rr_arb2 (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic       o_grant
);

    always_comb begin
        o_grant = 1'b0;
        if (&i_valid) begin
            o_grant = ~i_last;
        end else if (i_valid[1]) begin
            o_grant = 1'b1;
        end
    end

endmodule

// File: rtl/ipsl_pcie_dbi_apb_arb.sv
// Two-requester round-robin arbiter/sequencer for the DBI bridge APB port,
// with a watchdog that aborts transfers the bridge never completes.
module ipsl_pcie_dbi_apb_arb
    import ipsl_pcie_dbi_pkg::*;
#(
    parameter int unsigned TO_CYCLES = TO_CYCLES_DEF,
    parameter int unsigned TO_W      = TO_W_DEF
) (
    input  logic                    pclk_div2,
    input  logic                    apb_rst_n,
    ipsl_pcie_dbi_apb_arb_if.slave  bus,
    output logic                    busy,
    output logic [7:0]              to_count
);

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TO_CYCLES - 1);

    state_t            r_state;
    logic              r_last;
    logic              r_gnt;
    logic [TO_W-1:0]   r_cnt;
    logic              r_p_sel;
    logic              r_p_ce;
    logic              r_p_we;
    logic [15:0]       r_p_addr;
    logic [31:0]       r_p_wdata;
    logic [3:0]        r_p_strb;
    logic [1:0]        r_done;
    logic [1:0]        r_err;
    logic [1:0][31:0]  r_rdata;
    logic [7:0]        r_to_count;

    logic              w_gnt;
    logic              w_we;
    logic [15:0]       w_addr;
    logic [31:0]       w_wdata;
    logic [3:0]        w_strb;

    ipsl_pcie_rr_arb2 u_rr_arb2 (
        .i_valid ({bus.req1_valid, bus.req0_valid}),
        .i_last  (r_last),
        .o_grant (w_gnt)
    );

    always_comb begin
        w_we    = bus.req0_we;
        w_addr  = bus.req0_addr;
        w_wdata = bus.req0_wdata;
        w_strb  = bus.req0_strb;
        if (w_gnt) begin
            w_we    = bus.req1_we;
            w_addr  = bus.req1_addr;
            w_wdata = bus.req1_wdata;
            w_strb  = bus.req1_strb;
        end
    end

    always_ff @(posedge pclk_div2 or negedge apb_rst_n) begin
        if (!apb_rst_n) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_gnt      <= 1'b0;
            r_cnt      <= '0;
            r_p_sel    <= 1'b0;
            r_p_ce     <= 1'b0;
            r_p_we     <= 1'b0;
            r_p_addr   <= '0;
            r_p_wdata  <= '0;
            r_p_strb   <= '0;
            r_done     <= '0;
            r_err      <= '0;
            r_rdata    <= '0;
            r_to_count <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.req0_valid || bus.req1_valid) begin
                        r_gnt     <= w_gnt;
                        r_last    <= w_gnt;
                        r_p_sel   <= 1'b1;
                        r_p_ce    <= 1'b1;
                        r_p_we    <= w_we;
                        r_p_addr  <= w_addr;
                        r_p_wdata <= w_wdata;
                        r_p_strb  <= w_strb;
                        r_cnt     <= '0;
                        r_state   <= ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    // p_rdy takes priority over a watchdog expiry in the same cycle
                    if (bus.p_rdy || (r_cnt == TO_LAST)) begin
                        r_p_sel       <= 1'b0;
                        r_p_ce        <= 1'b0;
                        r_p_we        <= 1'b0;
                        r_done[r_gnt] <= 1'b1;
                        r_err[r_gnt]  <= ~bus.p_rdy;
                        r_state       <= ST_IDLE;
                        if (!bus.p_rdy) begin
                            r_rdata[r_gnt] <= '0;
                            if (r_to_count != 8'hFF) begin
                                r_to_count <= r_to_count + 8'd1;
                            end
                        end else if (!r_p_we) begin
                            r_rdata[r_gnt] <= bus.p_rdata;
                        end
                    end else begin
                        r_cnt <= r_cnt + TO_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.p_sel      = r_p_sel;
    assign bus.p_ce       = r_p_ce;
    assign bus.p_we       = r_p_we;
    assign bus.p_addr     = r_p_addr;
    assign bus.p_wdata    = r_p_wdata;
    assign bus.p_strb     = r_p_strb;
    assign bus.req0_done  = r_done[0];
    assign bus.req0_err   = r_err[0];
    assign bus.req0_rdata = r_rdata[0];
    assign bus.req1_done  = r_done[1];
    assign bus.req1_err   = r_err[1];
    assign bus.req1_rdata = r_rdata[1];
    assign busy           = (r_state == ST_ACCESS);
    assign to_count       = r_to_count;

endmodule

// File: tb/tb_ipsl_pcie_dbi_apb_arb.sv
// Self-checking bench: directed and random transfers against a transaction-level model.
module tb_ipsl_pcie_dbi_apb_arb;

    localparam int unsigned TO    = 8;
    localparam int unsigned NEVER = 1000;

    logic       pclk_div2 = 1'b0;
    logic       apb_rst_n = 1'b0;
    logic       busy;
    logic [7:0] to_count;

    ipsl_pcie_dbi_apb_arb_if bus ();

    ipsl_pcie_dbi_apb_arb #(.TO_CYCLES(TO), .TO_W(10)) dut (
        .pclk_div2 (pclk_div2),
        .apb_rst_n (apb_rst_n),
        .bus       (bus),
        .busy      (busy),
        .to_count  (to_count)
    );

    always #5 pclk_div2 = ~pclk_div2;

    typedef struct {
        bit          pend;
        bit          we;
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        int unsigned lat;
        logic [31:0] brdata;
    } req_t;

    req_t        rq [2];
    int unsigned m_last;
    int unsigned m_tocnt;
    logic [31:0] m_rdata [2];
    logic        m_err [2];
    bit          rand_mode;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic new_req(input int p, input bit we, input logic [15:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input int unsigned lat, input logic [31:0] brd);
        rq[p].pend   = 1'b1;
        rq[p].we     = we;
        rq[p].addr   = addr;
        rq[p].wdata  = wd;
        rq[p].strb   = st;
        rq[p].lat    = lat;
        rq[p].brdata = brd;
    endtask

    task automatic rand_req(input int p);
        new_req(p, 1'($urandom), 16'($urandom), $urandom, 4'($urandom), $urandom_range(0, TO + 2), $urandom);
    endtask

    task automatic set_port(input int p, input bit v, input bit we, input logic [15:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_we = we; bus.req0_addr = a; bus.req0_wdata = d; bus.req0_strb = s;
        end else begin
            bus.req1_valid = v; bus.req1_we = we; bus.req1_addr = a; bus.req1_wdata = d; bus.req1_strb = s;
        end
    endtask

    task automatic apply_req(input int p);
        set_port(p, rq[p].pend, rq[p].we, rq[p].addr, rq[p].wdata, rq[p].strb);
    endtask

    task automatic get_port(input int p, output logic d, output logic [31:0] r, output logic e);
        if (p == 0) begin d = bus.req0_done; r = bus.req0_rdata; e = bus.req0_err; end
        else        begin d = bus.req1_done; r = bus.req1_rdata; e = bus.req1_err; end
    endtask

    // done_port < 0: no completion expected this cycle
    task automatic check_ports(input int done_port);
        logic d, e;
        logic [31:0] r;
        for (int p = 0; p < 2; p++) begin
            get_port(p, d, r, e);
            check($sformatf("done%0d", p), d, (p == done_port) ? 1 : 0);
            check($sformatf("rdata%0d", p), r, m_rdata[p]);
            check($sformatf("err%0d", p), e, m_err[p]);
        end
    endtask

    task automatic check_access(input int w);
        check("p_sel_hi", bus.p_sel, 1);
        check("p_ce_hi", bus.p_ce, 1);
        check("busy_hi", busy, 1);
        check("p_we", bus.p_we, rq[w].we);
        check("p_addr", bus.p_addr, rq[w].addr);
        check("p_wdata", bus.p_wdata, rq[w].wdata);
        check("p_strb", bus.p_strb, rq[w].strb);
    endtask

    // Starts at a negedge with the DUT idle; returns at the negedge of the done cycle.
    task automatic run_grant();
        int          w, l;
        int unsigned dcyc;
        bit          tmo;
        if (rq[0].pend && rq[1].pend) w = 1 - int'(m_last);
        else                          w = rq[1].pend ? 1 : 0;
        l = 1 - w;
        apply_req(0);
        apply_req(1);
        bus.p_rdy   = 1'b0;
        bus.p_rdata = $urandom;
        @(negedge pclk_div2);
        check_access(w);
        check_ports(-1);
        tmo  = (rq[w].lat >= TO);
        dcyc = tmo ? TO : rq[w].lat + 1;
        for (int unsigned i = 0; i < dcyc; i++) begin
            bus.p_rdy   = (i == rq[w].lat);
            bus.p_rdata = (i == rq[w].lat) ? rq[w].brdata : $urandom;
            if (rand_mode && ($urandom_range(0, 3) == 0))
                set_port(w, 1'b0, 1'($urandom), 16'($urandom), $urandom, 4'($urandom));
            if (rand_mode && !rq[l].pend && ($urandom_range(0, 3) == 0)) begin
                rand_req(l);
                apply_req(l);
            end
            @(negedge pclk_div2);
            if (i + 1 < dcyc) begin
                check_access(w);
                check_ports(-1);
            end
        end
        if (tmo) begin
            m_err[w]   = 1'b1;
            m_rdata[w] = '0;
            if (m_tocnt < 255) m_tocnt++;
        end else begin
            m_err[w] = 1'b0;
            if (!rq[w].we) m_rdata[w] = rq[w].brdata;
        end
        check("p_sel_lo", bus.p_sel, 0);
        check("p_ce_lo", bus.p_ce, 0);
        check("p_we_lo", bus.p_we, 0);
        check("busy_lo", busy, 0);
        check("to_count", to_count, m_tocnt);
        check_ports(w);
        rq[w].pend  = 1'b0;
        m_last      = w;
        bus.p_rdy   = 1'b0;
        apply_req(w);
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge pclk_div2);
            check("idle_p_sel", bus.p_sel, 0);
            check("idle_busy", busy, 0);
            check_ports(-1);
        end
    endtask

    task automatic model_reset();
        m_last  = 1;
        m_tocnt = 0;
        for (int p = 0; p < 2; p++) begin
            m_rdata[p] = '0;
            m_err[p]   = 1'b0;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        rand_mode = 1'b0;
        for (int p = 0; p < 2; p++) begin
            rq[p].pend = 1'b0;
            set_port(p, 1'b0, 1'b0, '0, '0, '0);
        end
        bus.p_rdy   = 1'b0;
        bus.p_rdata = '0;
        model_reset();

        repeat (3) @(negedge pclk_div2);
        check("rst_p_sel", bus.p_sel, 0);
        check("rst_p_ce", bus.p_ce, 0);
        check("rst_p_we", bus.p_we, 0);
        check("rst_p_addr", bus.p_addr, 0);
        check("rst_p_wdata", bus.p_wdata, 0);
        check("rst_p_strb", bus.p_strb, 0);
        check("rst_busy", busy, 0);
        check("rst_to_count", to_count, 0);
        check_ports(-1);
        apb_rst_n = 1'b1;
        idle_cycles(1);

        // Tie after reset: port 0 first, then port 1
        new_req(0, 1'b0, 16'h0100, 32'h0, 4'hF, 2, 32'h1111_0000);
        new_req(1, 1'b0, 16'h0204, 32'h0, 4'hF, 1, 32'h2222_0000);
        run_grant();
        run_grant();
        idle_cycles(2);

        // Port 0 write with 3-cycle bridge latency
        new_req(0, 1'b1, 16'h0010, 32'hA5A5_5A5A, 4'hF, 3, 32'hDEAD_BEEF);
        run_grant();
        idle_cycles(1);

        // Port 1 back-to-back, then port 0 joins and wins the tie
        for (int k = 0; k < 3; k++) begin
            new_req(1, 1'($urandom), 16'($urandom), $urandom, 4'($urandom), $urandom_range(0, 4), $urandom);
            run_grant();
        end
        new_req(0, 1'b0, 16'h0300, 32'h0, 4'h3, 1, 32'h3333_0000);
        new_req(1, 1'b0, 16'h0304, 32'h0, 4'hC, 0, 32'h4444_0000);
        run_grant();
        run_grant();
        idle_cycles(1);

        // Watchdog abort, then p_rdy on the expiry cycle
        new_req(0, 1'b0, 16'h0400, 32'h0, 4'hF, NEVER, 32'h5555_0000);
        run_grant();
        idle_cycles(1);
        new_req(0, 1'b0, 16'h0404, 32'h0, 4'hF, TO - 1, 32'h6666_0000);
        run_grant();
        idle_cycles(1);

        // Randomized traffic
        rand_mode = 1'b1;
        for (int it = 0; it < 300; it++) begin
            if (!rq[0].pend && !rq[1].pend) begin
                idle_cycles($urandom_range(0, 2));
                case ($urandom_range(0, 2))
                    0: rand_req(0);
                    1: rand_req(1);
                    default: begin rand_req(0); rand_req(1); end
                endcase
            end
            run_grant();
        end
        rand_mode = 1'b0;
        while (rq[0].pend || rq[1].pend) run_grant();
        idle_cycles(1);

        // to_count saturation
        for (int k = 0; k < 260; k++) begin
            new_req(k % 2, 1'($urandom), 16'($urandom), $urandom, 4'($urandom), NEVER, $urandom);
            run_grant();
        end
        check("to_count_sat", to_count, 8'hFF);
        idle_cycles(1);

        // Asynchronous reset in the middle of ACCESS
        new_req(0, 1'b0, 16'h0500, 32'h0, 4'hF, NEVER, 32'h7777_0000);
        apply_req(0);
        @(negedge pclk_div2);
        check("pre_rst_p_sel", bus.p_sel, 1);
        #2 apb_rst_n = 1'b0;
        #1;
        check("arst_p_sel", bus.p_sel, 0);
        check("arst_p_ce", bus.p_ce, 0);
        check("arst_busy", busy, 0);
        check("arst_to_count", to_count, 0);
        model_reset();
        check_ports(-1);
        @(negedge pclk_div2);
        check_ports(-1);
        apb_rst_n = 1'b1;
        rq[0].lat = 2;
        run_grant();
        idle_cycles(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
